// File: rtl/sample_width_arbiter_pkg.sv
// sample_width_arbiter_pkg: channel identifiers and width-conversion helper | rev 1.0
`default_nettype none

package sample_width_arbiter_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Number of LSBs dropped when narrowing; zero when the output is as wide or wider.
  function automatic int trunc_offset(input int len_in, input int len_out);
    return (len_in > len_out) ? (len_in - len_out) : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_width_arbiter_sign_extend.sv
// sample_width_arbiter_sign_extend: signed width conversion (extend, pass or keep MSBs) | rev 1.0
`default_nettype none

module sample_width_arbiter_sign_extend
  import sample_width_arbiter_pkg::*;
#(
  parameter int LENGTH_IN  = 16,
  parameter int LENGTH_OUT = 20
) (
  input  logic [LENGTH_IN-1:0]  data_i,
  output logic [LENGTH_OUT-1:0] data_o
);

  generate
    if (LENGTH_OUT > LENGTH_IN) begin : g_extend
      assign data_o = {{(LENGTH_OUT-LENGTH_IN){data_i[LENGTH_IN-1]}}, data_i};
    end else if (LENGTH_OUT == LENGTH_IN) begin : g_pass
      assign data_o = data_i;
    end else begin : g_trunc
      localparam int OFF = trunc_offset(LENGTH_IN, LENGTH_OUT);
      logic w_unused_lsbs;
      // Plain truncation: the dropped LSBs are intentionally not rounded in.
      assign data_o        = data_i[LENGTH_IN-1:OFF];
      assign w_unused_lsbs = ^data_i[OFF-1:0];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sample_width_arbiter.sv
// sample_width_arbiter: round-robin share of one registered width-conversion stage
// between two valid/ready sample channels, with enables and saturating counters | rev 1.0
`default_nettype none

module sample_width_arbiter
  import sample_width_arbiter_pkg::*;
#(
  parameter int LENGTH_IN  = 16,
  parameter int LENGTH_OUT = 20,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            ch_en_i,
  input  logic                  in0_valid_i,
  input  logic [LENGTH_IN-1:0]  in0_data_i,
  output logic                  in0_ready_o,
  input  logic                  in1_valid_i,
  input  logic [LENGTH_IN-1:0]  in1_data_i,
  output logic                  in1_ready_o,
  output logic                  out_valid_o,
  output logic [LENGTH_OUT-1:0] out_data_o,
  output logic                  out_chan_o,
  input  logic                  out_ready_i,
  output logic [COUNT_W-1:0]    cnt0_o,
  output logic [COUNT_W-1:0]    cnt1_o
);

  logic                  out_valid_q, out_valid_d;
  logic [LENGTH_OUT-1:0] out_data_q,  out_data_d;
  logic                  out_chan_q,  out_chan_d;
  logic                  last_grant_q, last_grant_d;
  logic [COUNT_W-1:0]    cnt0_q, cnt0_d;
  logic [COUNT_W-1:0]    cnt1_q, cnt1_d;

  logic                  w_req0, w_req1;
  logic                  w_grant0, w_grant1;
  logic                  w_slot_free;
  logic                  w_accept0, w_accept1, w_accept;
  logic                  w_out_fire;
  logic [LENGTH_IN-1:0]  w_sel_data;
  logic [LENGTH_OUT-1:0] w_conv_data;

  assign w_req0 = in0_valid_i & ch_en_i[0];
  assign w_req1 = in1_valid_i & ch_en_i[1];

  // On contention the channel that did not win last time goes next.
  assign w_grant0 = w_req0 & (~w_req1 | (last_grant_q == CH1));
  assign w_grant1 = w_req1 & (~w_req0 | (last_grant_q == CH0));

  assign w_slot_free = ~out_valid_q | out_ready_i;
  assign in0_ready_o = w_grant0 & w_slot_free;
  assign in1_ready_o = w_grant1 & w_slot_free;

  assign w_accept0  = in0_valid_i & in0_ready_o;
  assign w_accept1  = in1_valid_i & in1_ready_o;
  assign w_accept   = w_accept0 | w_accept1;
  assign w_out_fire = out_valid_q & out_ready_i;

  assign w_sel_data = w_grant1 ? in1_data_i : in0_data_i;

  sample_width_arbiter_sign_extend #(
    .LENGTH_IN  (LENGTH_IN),
    .LENGTH_OUT (LENGTH_OUT)
  ) u_conv (
    .data_i (w_sel_data),
    .data_o (w_conv_data)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;

    if (w_out_fire) begin
      out_valid_d = 1'b0;
    end

    // A new accept overrides the clear so a consume+accept cycle keeps full rate.
    if (w_accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = w_conv_data;
      out_chan_d   = w_accept1 ? CH1 : CH0;
      last_grant_d = w_accept1 ? CH1 : CH0;
    end

    if (w_out_fire && (out_chan_q == CH0) && (cnt0_q != '1)) begin
      cnt0_d = cnt0_q + COUNT_W'(1);
    end
    if (w_out_fire && (out_chan_q == CH1) && (cnt1_q != '1)) begin
      cnt1_d = cnt1_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= CH0;
      last_grant_q <= CH1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_chan_o  = out_chan_q;
  assign cnt0_o      = cnt0_q;
  assign cnt1_o      = cnt1_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_width_arbiter.sv
// tb_sample_width_arbiter: directed checks of arbitration, conversion, backpressure and counters.
`default_nettype none

module tb_sample_width_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Main instance: 16 -> 20 sign extension, 16-bit counters.
  logic [1:0]  ch_en;
  logic        in0_valid, in1_valid, in0_ready, in1_ready;
  logic [15:0] in0_data, in1_data;
  logic        out_valid, out_chan, out_ready;
  logic [19:0] out_data;
  logic [15:0] cnt0, cnt1;

  sample_width_arbiter #(.LENGTH_IN(16), .LENGTH_OUT(20), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .ch_en_i(ch_en),
    .in0_valid_i(in0_valid), .in0_data_i(in0_data), .in0_ready_o(in0_ready),
    .in1_valid_i(in1_valid), .in1_data_i(in1_data), .in1_ready_o(in1_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_chan_o(out_chan),
    .out_ready_i(out_ready), .cnt0_o(cnt0), .cnt1_o(cnt1)
  );

  // Truncating instance: 20 -> 16.
  logic        t_in0_valid, t_in1_valid, t_in0_ready, t_in1_ready;
  logic [19:0] t_in0_data, t_in1_data;
  logic        t_out_valid, t_out_chan, t_out_ready;
  logic [15:0] t_out_data;
  logic [15:0] t_cnt0, t_cnt1;

  sample_width_arbiter #(.LENGTH_IN(20), .LENGTH_OUT(16), .COUNT_W(16)) dut_t (
    .clk(clk), .rst(rst), .ch_en_i(2'b11),
    .in0_valid_i(t_in0_valid), .in0_data_i(t_in0_data), .in0_ready_o(t_in0_ready),
    .in1_valid_i(t_in1_valid), .in1_data_i(t_in1_data), .in1_ready_o(t_in1_ready),
    .out_valid_o(t_out_valid), .out_data_o(t_out_data), .out_chan_o(t_out_chan),
    .out_ready_i(t_out_ready), .cnt0_o(t_cnt0), .cnt1_o(t_cnt1)
  );

  // Saturation instance: 2-bit counters.
  logic [1:0]  s_ch_en;
  logic        s_in0_valid, s_in1_valid, s_in0_ready, s_in1_ready;
  logic [15:0] s_in0_data, s_in1_data;
  logic        s_out_valid, s_out_chan, s_out_ready;
  logic [19:0] s_out_data;
  logic [1:0]  s_cnt0, s_cnt1;

  sample_width_arbiter #(.LENGTH_IN(16), .LENGTH_OUT(20), .COUNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .ch_en_i(s_ch_en),
    .in0_valid_i(s_in0_valid), .in0_data_i(s_in0_data), .in0_ready_o(s_in0_ready),
    .in1_valid_i(s_in1_valid), .in1_data_i(s_in1_data), .in1_ready_o(s_in1_ready),
    .out_valid_o(s_out_valid), .out_data_o(s_out_data), .out_chan_o(s_out_chan),
    .out_ready_i(s_out_ready), .cnt0_o(s_cnt0), .cnt1_o(s_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ch_en = 2'b11; in0_valid = 0; in1_valid = 0; in0_data = '0; in1_data = '0; out_ready = 0;
    t_in0_valid = 0; t_in1_valid = 0; t_in0_data = '0; t_in1_data = '0; t_out_ready = 0;
    s_ch_en = 2'b11; s_in0_valid = 0; s_in1_valid = 0; s_in0_data = '0; s_in1_data = '0;
    s_out_ready = 0;

    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_chan",  32'(out_chan),  32'd0);
    check("rst_cnt0",      32'(cnt0),      32'd0);
    check("rst_cnt1",      32'(cnt1),      32'd0);
    rst = 0;

    // Sign extension, channel 0 alone.
    in0_valid = 1; in0_data = 16'h8001; out_ready = 1;
    #1;
    check("se_in0_ready", 32'(in0_ready), 32'd1);
    check("se_in1_ready", 32'(in1_ready), 32'd0);
    tick();
    check("se_valid", 32'(out_valid), 32'd1);
    check("se_neg",   32'(out_data),  32'h000F8001);
    check("se_chan",  32'(out_chan),  32'd0);
    in0_data = 16'h7FFF;
    tick();
    check("se_pos",     32'(out_data), 32'h00007FFF);
    check("se_cnt0_a",  32'(cnt0),     32'd1);
    in0_data = 16'h1234;
    tick();
    check("se_next",    32'(out_data), 32'h00001234);
    check("se_cnt0_b",  32'(cnt0),     32'd2);

    // Asynchronous reset mid-cycle discards the pending sample.
    in0_valid = 0; out_ready = 0;
    #3 rst = 1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_cnt0",      32'(cnt0),      32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    tick();
    rst = 0;

    // Round-robin with both channels valid.
    in0_valid = 1; in0_data = 16'h0001; in1_valid = 1; in1_data = 16'h0002; out_ready = 1;
    #1;
    check("rr_first_in0_ready", 32'(in0_ready), 32'd1);
    check("rr_first_in1_ready", 32'(in1_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_chan", 32'(out_chan), 32'(k % 2));
      check("rr_data", 32'(out_data), (k % 2 == 1) ? 32'd2 : 32'd1);
    end
    check("rr_cnt0", 32'(cnt0), 32'd2);
    check("rr_cnt1", 32'(cnt1), 32'd2);

    // Backpressure: channel 0 sample held, nobody granted-ready.
    out_ready = 0;
    in0_data = 16'h0BAD;
    #1;
    check("bp_in0_ready", 32'(in0_ready), 32'd0);
    check("bp_in1_ready", 32'(in1_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data",  32'(out_data),  32'd1);
      check("bp_chan",  32'(out_chan),  32'd0);
      check("bp_ready", 32'({in0_ready, in1_ready}), 32'd0);
    end
    check("bp_cnt0", 32'(cnt0), 32'd2);
    out_ready = 1;
    #1;
    check("bp_rel_in1_ready", 32'(in1_ready), 32'd1);
    check("bp_rel_in0_ready", 32'(in0_ready), 32'd0);
    tick();
    check("bp_rel_valid", 32'(out_valid), 32'd1);
    check("bp_rel_chan",  32'(out_chan),  32'd1);
    check("bp_rel_data",  32'(out_data),  32'd2);
    check("bp_rel_cnt0",  32'(cnt0),      32'd3);
    in0_valid = 0; in1_valid = 0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_cnt1",  32'(cnt1),      32'd3);
    check("drain_hold",  32'(out_data),  32'd2);

    // Truncation instance.
    t_in1_valid = 1; t_in1_data = 20'hABCDE; t_out_ready = 1;
    tick();
    check("tr_data", 32'(t_out_data), 32'h0000ABCD);
    check("tr_chan", 32'(t_out_chan), 32'd1);
    t_in1_valid = 0; t_in0_valid = 1; t_in0_data = 20'h8000F;
    tick();
    check("tr_data0", 32'(t_out_data), 32'h00008000);
    check("tr_chan0", 32'(t_out_chan), 32'd0);
    t_in0_valid = 0;

    // Enable gating and counter saturation.
    s_ch_en = 2'b10; s_in0_valid = 1; s_in1_valid = 1;
    s_in0_data = 16'h0011; s_in1_data = 16'h0022; s_out_ready = 1;
    #1;
    check("en_in0_ready", 32'(s_in0_ready), 32'd0);
    check("en_in1_ready", 32'(s_in1_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("en_chan", 32'(s_out_chan), 32'd1);
      check("sat_cnt1", 32'(s_cnt1), (k < 3) ? 32'(k) : 32'd3);
    end
    check("en_cnt0", 32'(s_cnt0), 32'd0);
    s_in0_valid = 0; s_in1_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
